// File: rtl/r5_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : r5_stage_ctrl
// Brief    : Radix-5 FFT stage sequencer: groups samples, times butterfly
//            output windows, twiddle exponents and frame boundaries.
//            Optional macro R5_TWIDDLE_EN enables the twiddle accumulator.
// Revision : 1.0 - initial release
// ============================================================================
module r5_stage_ctrl #(
  parameter int N_PTS  = 25,
  parameter int BF_LAT = 2,
  localparam int c_NGRP  = N_PTS / 5,
  localparam int c_GRP_W = (c_NGRP > 1) ? $clog2(c_NGRP) : 1,
  localparam int c_TW_W  = $clog2(N_PTS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_in_valid,
  input  logic               i_err_clr,
  output logic               o_bf_load,
  output logic [c_GRP_W-1:0] o_grp_idx,
  output logic               o_out_valid,
  output logic [2:0]         o_out_idx,
  output logic [c_TW_W-1:0]  o_tw_exp,
  output logic               o_frame_done,
  output logic               o_err_gap
);

  localparam logic [c_GRP_W-1:0] c_LAST_G = c_GRP_W'(c_NGRP - 1);

  typedef enum logic [0:0] {
    W_IDLE = 1'b0,
    W_RUN  = 1'b1
  } win_state_t;

  logic [2:0]         r_cnt;
  logic [c_GRP_W-1:0] r_g;
  logic [c_GRP_W-1:0] r_grp_idx;
  logic               r_err;
  logic [BF_LAT-1:0]  r_pv;
  logic [c_GRP_W-1:0] r_pg [BF_LAT];

  win_state_t         r_state;
  win_state_t         w_state_nxt;
  logic               r_out_valid;
  logic [2:0]         r_m;
  logic [c_GRP_W-1:0] r_gw;
  logic               r_fd;

  logic               w_grp_done;
  logic               w_gap;
  logic               w_start;
  logic               w_ov_nxt;
  logic [2:0]         w_m_nxt;
  logic [c_GRP_W-1:0] w_gw_nxt;
  logic               w_fd_nxt;

  assign w_grp_done = i_in_valid && (r_cnt == 3'd4);
  assign w_gap      = !i_in_valid && (r_cnt != 3'd0);

  // Group assembly: a missing sample inside a group discards it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= 3'd0;
      r_g       <= '0;
      r_grp_idx <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_grp_done || !i_in_valid) begin
        r_cnt <= 3'd0;
      end else begin
        r_cnt <= r_cnt + 3'd1;
      end
      if (w_grp_done) begin
        r_grp_idx <= r_g;
        r_g       <= (r_g == c_LAST_G) ? '0 : r_g + c_GRP_W'(1);
      end
      r_err <= w_gap | (r_err & ~i_err_clr);
    end
  end

  // Load pulse and its group number travel BF_LAT stages; the last stage
  // fires one cycle early so the registered window lands on bf_load+BF_LAT.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BF_LAT; i++) begin
        r_pv[i] <= 1'b0;
        r_pg[i] <= '0;
      end
    end else begin
      r_pv[0] <= w_grp_done;
      r_pg[0] <= r_g;
      for (int i = 1; i < BF_LAT; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pg[i] <= r_pg[i-1];
      end
    end
  end

  assign w_start = r_pv[BF_LAT-1];

  always_comb begin
    w_state_nxt = r_state;
    w_ov_nxt    = 1'b0;
    w_m_nxt     = 3'd0;
    w_gw_nxt    = r_gw;
    w_fd_nxt    = 1'b0;
    if (w_start) begin
      w_state_nxt = W_RUN;
      w_ov_nxt    = 1'b1;
      w_gw_nxt    = r_pg[BF_LAT-1];
    end else if (r_state == W_RUN) begin
      if (r_m == 3'd4) begin
        w_state_nxt = W_IDLE;
      end else begin
        w_ov_nxt = 1'b1;
        w_m_nxt  = r_m + 3'd1;
      end
    end
    w_fd_nxt = w_ov_nxt && (w_m_nxt == 3'd4) && (w_gw_nxt == c_LAST_G);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= W_IDLE;
      r_out_valid <= 1'b0;
      r_m         <= 3'd0;
      r_gw        <= '0;
      r_fd        <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= w_ov_nxt;
      r_m         <= w_m_nxt;
      r_gw        <= w_gw_nxt;
      r_fd        <= w_fd_nxt;
    end
  end

`ifdef R5_TWIDDLE_EN
  logic [c_TW_W-1:0] r_tw;
  logic [c_TW_W-1:0] w_tw_nxt;

  // g*m built by repeated addition of the window's group number.
  always_comb begin
    w_tw_nxt = '0;
    if (!w_start && w_ov_nxt) begin
      w_tw_nxt = r_tw + c_TW_W'(r_gw);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tw <= '0;
    end else begin
      r_tw <= w_tw_nxt;
    end
  end

  assign o_tw_exp = r_tw;
`else
  assign o_tw_exp = '0;
`endif

  assign o_bf_load    = r_pv[0];
  assign o_grp_idx    = r_grp_idx;
  assign o_out_valid  = r_out_valid;
  assign o_out_idx    = r_m;
  assign o_frame_done = r_fd;
  assign o_err_gap    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_r5_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_r5_stage_ctrl
// Brief    : Directed self-checking bench for r5_stage_ctrl (N_PTS=25,
//            BF_LAT=2); twiddle expectations follow R5_TWIDDLE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_r5_stage_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       err_clr;
  logic       bf_load;
  logic [2:0] grp_idx;
  logic       out_valid;
  logic [2:0] out_idx;
  logic [4:0] tw_exp;
  logic       frame_done;
  logic       err_gap;

  int checks = 0;
  int errors = 0;

  logic [63:0] m_in, m_clr, m_rst, e_ld, e_ov, e_fd, e_err;

  r5_stage_ctrl #(.N_PTS(25), .BF_LAT(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_in_valid   (in_valid),
    .i_err_clr    (err_clr),
    .o_bf_load    (bf_load),
    .o_grp_idx    (grp_idx),
    .o_out_valid  (out_valid),
    .o_out_idx    (out_idx),
    .o_tw_exp     (tw_exp),
    .o_frame_done (frame_done),
    .o_err_gap    (err_gap)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] rng(input int lo, input int hi);
    logic [63:0] r;
    r = '0;
    for (int i = lo; i <= hi; i++) r[i] = 1'b1;
    return r;
  endfunction

  task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d: observed %0d expected %0d", tag, c, obs, exp);
    end
  endtask

  // Cycle 0 is the first cycle after reset release; outputs sampled 1 time
  // unit after the rising edge that opens each cycle.
  task automatic run(input string name, input int ncyc);
    int   n_ld;
    int   pos;
    logic prev_rst;
    n_ld     = 0;
    pos      = 0;
    prev_rst = 1'b1;
    rst      = 1'b1;
    in_valid = 1'b0;
    err_clr  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int c = 0; c < ncyc; c++) begin
      rst      = m_rst[c];
      in_valid = m_in[c];
      err_clr  = m_clr[c];
      chk({name, ".bf_load"},    c, 32'(bf_load),    32'(e_ld[c]));
      chk({name, ".out_valid"},  c, 32'(out_valid),  32'(e_ov[c]));
      chk({name, ".frame_done"}, c, 32'(frame_done), 32'(e_fd[c]));
      chk({name, ".err_gap"},    c, 32'(err_gap),    32'(e_err[c]));
      if (prev_rst) begin
        chk({name, ".rst_grp_idx"}, c, 32'(grp_idx), 32'd0);
        chk({name, ".rst_out_idx"}, c, 32'(out_idx), 32'd0);
        chk({name, ".rst_tw_exp"},  c, 32'(tw_exp),  32'd0);
      end
      if (e_ld[c]) begin
        chk({name, ".grp_idx"}, c, 32'(grp_idx), 32'(n_ld % 5));
        n_ld++;
      end
      if (e_ov[c]) begin
        chk({name, ".out_idx"}, c, 32'(out_idx), 32'(pos % 5));
`ifdef R5_TWIDDLE_EN
        chk({name, ".tw_exp"}, c, 32'(tw_exp), 32'(((pos / 5) % 5) * (pos % 5)));
`else
        chk({name, ".tw_exp"}, c, 32'(tw_exp), 32'd0);
`endif
        pos++;
      end
      prev_rst = m_rst[c];
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // Full frame, continuous input
    m_in = rng(0, 24); m_clr = '0; m_rst = '0;
    e_ld = '0; e_ld[5] = 1'b1; e_ld[10] = 1'b1; e_ld[15] = 1'b1; e_ld[20] = 1'b1; e_ld[25] = 1'b1;
    e_ov = rng(7, 31); e_fd = '0; e_fd[31] = 1'b1; e_err = '0;
    run("frame", 36);

    // Gap inside a group, then err_clr
    m_in = rng(0, 1) | rng(3, 7); m_clr = '0; m_clr[10] = 1'b1; m_rst = '0;
    e_ld = '0; e_ld[8] = 1'b1;
    e_ov = rng(10, 14); e_fd = '0; e_err = rng(3, 10);
    run("gap", 20);

    // Two frames, group counter wraps
    m_in = rng(0, 49); m_clr = '0; m_rst = '0;
    e_ld = '0;
    for (int k = 1; k <= 10; k++) e_ld[5*k] = 1'b1;
    e_ov = rng(7, 56); e_fd = '0; e_fd[31] = 1'b1; e_fd[56] = 1'b1; e_err = '0;
    run("wrap", 62);

    // Reset in the middle of an output window
    m_in = rng(0, 4); m_clr = '0; m_rst = '0; m_rst[8] = 1'b1;
    e_ld = '0; e_ld[5] = 1'b1;
    e_ov = rng(7, 8); e_fd = '0; e_err = '0;
    run("midrst", 20);

    // Idle gap between whole groups is legal
    m_in = rng(0, 4) | rng(10, 14); m_clr = '0; m_rst = '0;
    e_ld = '0; e_ld[5] = 1'b1; e_ld[15] = 1'b1;
    e_ov = rng(7, 11) | rng(17, 21); e_fd = '0; e_err = '0;
    run("spaced", 26);

    // err_clr coinciding with a new gap keeps err_gap set
    m_in = rng(0, 1); m_clr = '0; m_clr[2] = 1'b1; m_rst = '0;
    e_ld = '0; e_ov = '0; e_fd = '0; e_err = rng(3, 9);
    run("clrgap", 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
